spi_master: RTL and testbench
=============================

# spi_master

Initiator end of the error-correcting SPI link. The block accepts an 11-bit word from the host, Hamming(16,11) SECDED-encodes it, and drives the framing select and serial data out for one 16-bit frame. During the same frame it shifts in the responder's 16-bit packet, then decodes and corrects it and returns 11 bits of data with error flags. It runs on the same clock as the responder; the select is active-high and brackets exactly 16 bit cycles.

## Interface
- No parameters; packet width 16, data width 11, fixed.
- clk_in  input  1  system/bit clock; all state on rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  request a frame; sampled only when not busy
- data_from_host  input  11  word to transmit; captured on the accepted start edge
- msg_in  input  1  serial data from responder
- ss  output  1  frame select, high for exactly 16 cycles per frame
- msg_out  output  1  serial data to responder, MSB first
- busy  output  1  frame or decode in progress
- done  output  1  one-cycle pulse: data_to_host and error flags updated
- data_to_host  output  11  decoded/corrected received word
- single_err  output  1  last frame had a single-bit error (sticky until next done)
- double_err  output  1  last frame had an uncorrectable double error

## Operation
- Packet layout: packet[15:1] = Hamming positions 15..1; parity bits at positions 1, 2, 4, 8; data d0..d10 at positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15 (ascending); packet[0] = overall even parity of packet[15:1].
- Parity pK = XOR of all positions whose index has bit K set.
- FSM states:
  - IDLE: on start=1, encode data_from_host into the TX shift register, clear the 4-bit bit counter, go to SHIFT.
  - SHIFT: ss=1; msg_out = TX[15]; at each edge shift TX left and shift msg_in into RX[0]; the counter increments. When the counter = 15 at the edge, go to DECODE.
  - DECODE: ss=0; compute the syndrome s[3:0] (XOR of indices of set bits in RX[15:1]) and overall parity P = XOR of RX[15:0]. At the edge, register the outputs, assert done, and go to IDLE.
- Decode rules:
  - s=0, P=0: clean.
  - P=1: single error. If s≠0, flip position s; if s=0, the error is in packet[0] and data is unchanged. Set single_err=1.
  - s≠0, P=0: double error. Set double_err=1; data_to_host = uncorrected extracted bits.
- start while busy is ignored, not queued.
- start during the done cycle (state IDLE) is accepted, which gives back-to-back frames.
- msg_out = 0 whenever ss=0.
- Reset values: ss=0, msg_out=0, busy=0, done=0, data_to_host=0, single_err=0, double_err=0, state IDLE, counter 0, TX/RX 0.
- Reset mid-frame aborts immediately: ss drops asynchronously and no done is produced.

## Timing
- start accepted at edge E0. Bit i (packet[15−i]) is on msg_out during cycle i after E0, i=0..15. msg_in is sampled at the end of that cycle.
- ss is high for cycles 0..15, 16 cycles total.
- Cycle 16 is DECODE, with busy=1 and ss=0.
- done, data_to_host and the flags become valid in cycle 17, one cycle after DECODE.
- busy is high in cycles 0..16.
- Start-to-done latency is 18 edges. Minimum frame period is 18 cycles.

## Configuration
- SPI_MASTER_CORRECT_EN defined: single errors are corrected as above.
- SPI_MASTER_CORRECT_EN undefined:
  - Detection only: data_to_host is always the uncorrected extracted bits.
  - single_err and double_err are still computed identically.
  - No correction logic is synthesized.

## Test plan
- Reset, then start with data_from_host=11'h000, msg_in tied to msg_out: the serial stream is 16'h0000 and ss is high for 16 cycles. done arrives 18 edges after start with data_to_host=11'h000 and both flags 0.
- start with 11'h7FF in loopback: the stream is 16'hFFFF and the result is 11'h7FF, no errors.
- 11'h000 in loopback with packet[5] inverted in flight:
  - With macro: data_to_host=11'h000, single_err=1.
  - Without macro: data_to_host=11'h002, single_err=1.
- 11'h000 with packet[3] and packet[5] inverted: double_err=1, single_err=0.
- 11'h7FF with only packet[0] inverted: data_to_host=11'h7FF, single_err=1.
- Assert start every cycle: frames run back-to-back with one done per 18 cycles. Also assert reset in bit cycle 7: ss, busy and msg_out go to 0 immediately and no done follows.

Source files
------------

// File: rtl/spi_master.sv
// SPI initiator with Hamming(16,11) SECDED encode on transmit and decode on receive.
// Define SPI_MASTER_CORRECT_EN to enable single-error correction (detection-only otherwise).
module spi_master (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] data_from_host,
  input  logic        msg_in,
  output logic        ss,
  output logic        msg_out,
  output logic        busy,
  output logic        done,
  output logic [10:0] data_to_host,
  output logic        single_err,
  output logic        double_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_DECODE = 2'd2;

  localparam logic [3:0] DPOS [11] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10,
    4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_tx;
  logic [15:0] r_rx;
  logic        r_done;
  logic [10:0] r_data;
  logic        r_single;
  logic        r_double;

  logic [15:0] w_enc;
  logic [3:0]  w_syn;
  logic        w_par;
  logic [10:0] w_raw;
  logic [10:0] w_data;
  logic        w_corr;

  function automatic logic [15:0] f_encode(input logic [10:0] d);
    logic [15:0] p;
    p = '0;
    for (int k = 0; k < 11; k++) p[DPOS[k]] = d[k];
    // Each mask selects the data positions whose index has bit K set.
    p[1] = ^(p & 16'hAAA8);
    p[2] = ^(p & 16'hCCC8);
    p[4] = ^(p & 16'hF0E0);
    p[8] = ^(p & 16'hFE00);
    p[0] = ^p[15:1];
    return p;
  endfunction

  assign w_enc = f_encode(data_from_host);

  assign w_syn[0] = ^(r_rx & 16'hAAAA);
  assign w_syn[1] = ^(r_rx & 16'hCCCC);
  assign w_syn[2] = ^(r_rx & 16'hF0F0);
  assign w_syn[3] = ^(r_rx & 16'hFF00);
  assign w_par    = ^r_rx;

`ifdef SPI_MASTER_CORRECT_EN
  assign w_corr = w_par && (w_syn != 4'd0);
`else
  assign w_corr = 1'b0;
`endif

  always_comb begin
    w_raw  = '0;
    w_data = '0;
    for (int k = 0; k < 11; k++) begin
      w_raw[k]  = r_rx[DPOS[k]];
      w_data[k] = w_raw[k] ^ (w_corr && (w_syn == DPOS[k]));
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_done   <= 1'b0;
      r_data   <= '0;
      r_single <= 1'b0;
      r_double <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_tx    <= w_enc;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_tx  <= {r_tx[14:0], 1'b0};
          r_rx  <= {r_rx[14:0], msg_in};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_data   <= w_data;
          r_single <= w_par;
          r_double <= !w_par && (w_syn != 4'd0);
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Combinational from state so reset drops the select immediately.
  assign ss           = (r_state == S_SHIFT);
  assign msg_out      = ss & r_tx[15];
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign data_to_host = r_data;
  assign single_err   = r_single;
  assign double_err   = r_double;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: vector table of framed transfers
// plus back-to-back and mid-frame reset sequences.
module tb_spi_master;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] data_from_host;
  logic        msg_in;
  logic        ss;
  logic        msg_out;
  logic        busy;
  logic        done;
  logic [10:0] data_to_host;
  logic        single_err;
  logic        double_err;

  int checks = 0;
  int errors = 0;

  spi_master dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .start          (start),
    .data_from_host (data_from_host),
    .msg_in         (msg_in),
    .ss             (ss),
    .msg_out        (msg_out),
    .busy           (busy),
    .done           (done),
    .data_to_host   (data_to_host),
    .single_err     (single_err),
    .double_err     (double_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [10:0] din;
    logic [15:0] flip;
    logic [15:0] stream;
    logic [10:0] dcorr;
    logic [10:0] dnocorr;
    logic        se;
    logic        de;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    int          n;
    logic        ss_ok;
    logic [15:0] got;
    logic [10:0] exp_d;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    chk($sformatf("idle_wait%0d", idx), {15'd0, busy}, 16'd0);
    @(negedge clk_in);
    start = 1'b1;
    data_from_host = v.din;
    @(posedge clk_in);
    #1 start = 1'b0;
    ss_ok = 1'b1;
    got = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      if (ss !== 1'b1) ss_ok = 1'b0;
      got[15-i] = msg_out;
      msg_in = msg_out ^ v.flip[15-i];
    end
    chk($sformatf("ss_high%0d", idx), {15'd0, ss_ok}, 16'd1);
    chk($sformatf("stream%0d", idx), got, v.stream);
    @(negedge clk_in);
    msg_in = 1'b0;
    chk($sformatf("dec_state%0d", idx),
        {13'd0, ss, busy, done}, 16'b010);
    @(negedge clk_in);
`ifdef SPI_MASTER_CORRECT_EN
    exp_d = v.dcorr;
`else
    exp_d = v.dnocorr;
`endif
    chk($sformatf("done%0d", idx), {14'd0, done, busy}, 16'b10);
    chk($sformatf("data%0d", idx), {5'd0, data_to_host}, {5'd0, exp_d});
    chk($sformatf("flags%0d", idx), {14'd0, single_err, double_err},
        {14'd0, v.se, v.de});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dcnt;
    int dcyc [4];
    int n;

    tv[0] = '{11'h000, 16'h0000, 16'h0000, 11'h000, 11'h000, 1'b0, 1'b0};
    tv[1] = '{11'h7FF, 16'h0000, 16'hFFFF, 11'h7FF, 11'h7FF, 1'b0, 1'b0};
    tv[2] = '{11'h000, 16'h0020, 16'h0000, 11'h000, 11'h002, 1'b1, 1'b0};
    tv[3] = '{11'h000, 16'h0028, 16'h0000, 11'h003, 11'h003, 1'b0, 1'b1};
    tv[4] = '{11'h7FF, 16'h0001, 16'hFFFF, 11'h7FF, 11'h7FF, 1'b1, 1'b0};
    tv[5] = '{11'h001, 16'h0000, 16'h000F, 11'h001, 11'h001, 1'b0, 1'b0};
    tv[6] = '{11'h400, 16'h8000, 16'h8117, 11'h400, 11'h000, 1'b1, 1'b0};
    tv[7] = '{11'h001, 16'h0100, 16'h000F, 11'h001, 11'h001, 1'b1, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    data_from_host = '0;
    msg_in = 1'b0;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    chk("reset_outs",
        {10'd0, ss, msg_out, busy, done, single_err, double_err}, 16'd0);
    chk("reset_data", {5'd0, data_to_host}, 16'd0);

    for (int k = 0; k < 8; k++) run_frame(k, tv[k]);

    // Start held high: frames must chain with one done every 18 cycles.
    @(negedge clk_in);
    start = 1'b1;
    data_from_host = 11'h000;
    msg_in = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_in);
      if (done) begin
        if (dcnt < 4) dcyc[dcnt] = c;
        dcnt++;
      end
    end
    start = 1'b0;
    chk("b2b_count", dcnt[15:0], 16'd3);
    if (dcnt >= 3) begin
      chk("b2b_first", dcyc[0][15:0], 16'd17);
      chk("b2b_gap1", dcyc[1][15:0] - dcyc[0][15:0], 16'd18);
      chk("b2b_gap2", dcyc[2][15:0] - dcyc[1][15:0], 16'd18);
    end
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    chk("b2b_drain", {15'd0, busy}, 16'd0);

    // Reset during bit cycle 7 of an all-ones frame.
    @(negedge clk_in);
    start = 1'b1;
    data_from_host = 11'h7FF;
    @(posedge clk_in);
    #1 start = 1'b0;
    repeat (8) @(negedge clk_in);
    chk("mid_pre", {13'd0, ss, busy, msg_out}, 16'b111);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst", {13'd0, ss, busy, msg_out}, 16'd0);
    chk("mid_rst_data", {5'd0, data_to_host}, 16'd0);
    @(negedge clk_in);
    reset = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_in);
      if (done || ss || busy) dcnt++;
    end
    chk("mid_no_done", dcnt[15:0], 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
